// File: rtl/popcount_pattern_gen_pkg.sv
// Shared types and helpers for the popcount pattern generator.
package popcount_pkg;

    // Generator control states: waiting for a command, or streaming patterns.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width needed to hold a population count of an n-bit word (0..n).
    function automatic int countWidth(input int n);
        return $clog2(n + 1);
    endfunction

    // Binomial coefficient C(n,k); the number of n-bit words with k ones.
    function automatic int binom(input int n, input int k);
        int result;
        result = 1;
        if (k < 0 || k > n) begin
            return 0;
        end
        for (int i = 1; i <= k; i++) begin
            result = result * (n - k + i) / i;
        end
        return result;
    endfunction

endpackage

// File: rtl/popcount_pattern_gen_if.sv
// Command and output handshake bundle for the pattern generator.
// The master side issues commands and consumes words; the slave is the generator.
interface popcount_pattern_gen_if #(
    parameter int N = 7
);
    import popcount_pkg::*;

    localparam int CW = countWidth(N);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_count;
    logic          cmd_err;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_last;

    modport master (
        output cmd_valid, cmd_count, out_ready,
        input  cmd_ready, cmd_err, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd_count, out_ready,
        output cmd_ready, cmd_err, out_valid, out_data, out_last
    );

endinterface

// File: rtl/popcount_pattern_gen_tz.sv
// Trailing-zero counter: index of the lowest set bit of i_value.
// An all-zero input yields 0; callers never rely on that case.
module trailing_zero_count #(
    parameter int N = 7
) (
    input  logic [N-1:0]         i_value,
    output logic [$clog2(N)-1:0] o_tz
);
    localparam int TZW = $clog2(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_value[i]) begin
                o_tz = TZW'(i);
            end
        end
    end

endmodule

// File: rtl/popcount_pattern_gen.sv
// Streams every N-bit word with exactly k ones, in increasing order,
// one word per cycle, using Gosper's successor without a divider.
module popcount_pattern_gen
    import popcount_pkg::*;
#(
    parameter int N = 7
) (
    input logic                  clk,
    input logic                  rst,
    popcount_pattern_gen_if.slave bus
);
    localparam int CW  = countWidth(N);
    localparam int TZW = $clog2(N);

    state_t         r_state;
    state_t         w_nextState;
    logic [N-1:0]   r_pattern;
    logic [CW-1:0]  r_k;
    logic           r_err;

    logic           w_cmdReady;
    logic           w_outValid;
    logic           w_accept;
    logic           w_badCount;
    logic           w_outFire;
    logic           w_last;
    logic [N-1:0]   w_startPattern;
    logic [N-1:0]   w_lastPattern;
    logic [N-1:0]   w_nextPattern;
    logic [N:0]     w_x;
    logic [N:0]     w_c;
    logic [N:0]     w_r;
    logic [N:0]     w_diff;
    logic [N-2:0]   w_spread;
    logic [TZW-1:0] w_tz;

    assign w_accept   = bus.cmd_valid && w_cmdReady;
    assign w_badCount = int'(bus.cmd_count) > N;
    assign w_outFire  = w_outValid && bus.out_ready;

    // First pattern is the k lowest bits set; the final one is the k highest bits set.
    always_comb begin
        w_startPattern = '0;
        w_lastPattern  = '0;
        for (int i = 0; i < N; i++) begin
            w_startPattern[i] = (i < int'(bus.cmd_count));
            w_lastPattern[i]  = (i + int'(r_k) >= N);
        end
    end

    assign w_last = (r_pattern == w_lastPattern);

    trailing_zero_count #(.N(N)) u_tz (
        .i_value (r_pattern),
        .o_tz    (w_tz)
    );

    // Gosper's successor in N+1 bits; the shift by tz replaces the usual divide.
    // (r ^ x) >> 2 always has its top two bits clear, so it fits in N-1 bits.
    assign w_x           = {1'b0, r_pattern};
    assign w_c           = w_x & (-w_x);
    assign w_r           = w_x + w_c;
    assign w_diff        = w_r ^ w_x;
    assign w_spread      = w_diff[N:2] >> w_tz;
    assign w_nextPattern = w_r[N-1:0] | {1'b0, w_spread};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs; RUN leaves only after the last word is taken.
    always_comb begin
        w_nextState = r_state;
        w_cmdReady  = 1'b0;
        w_outValid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cmdReady = 1'b1;
                if (bus.cmd_valid && !w_badCount) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_outValid = 1'b1;
                if (bus.out_ready && w_last) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Pattern, latched count and error pulse; the pattern only advances on a taken word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= '0;
            r_k       <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && w_badCount;
            if (w_accept && !w_badCount) begin
                r_pattern <= w_startPattern;
                r_k       <= bus.cmd_count;
            end else if (w_outFire && !w_last) begin
                r_pattern <= w_nextPattern;
            end
        end
    end

    assign bus.cmd_ready = w_cmdReady;
    assign bus.cmd_err   = r_err;
    assign bus.out_valid = w_outValid;
    assign bus.out_data  = r_pattern;
    assign bus.out_last  = w_outValid && w_last;

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Scoreboard bench for popcount_pattern_gen: an N=7 instance for sequence
// checks and an N=5 instance for the out-of-range count error path.
module tb_popcount_pattern_gen;
    import popcount_pkg::*;

    localparam int N7  = 7;
    localparam int N5  = 5;
    localparam int CW7 = countWidth(N7);
    localparam int CW5 = countWidth(N5);

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   failCount  = 0;
    exp_t expQ[$];

    popcount_pattern_gen_if #(.N(N7)) bus7 ();
    popcount_pattern_gen_if #(.N(N5)) bus5 ();

    popcount_pattern_gen #(.N(N7)) dut7 (
        .clk (clk),
        .rst (rst),
        .bus (bus7.slave)
    );

    popcount_pattern_gen #(.N(N5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference enumeration: scan all n-bit words in order and keep those with k ones.
    task automatic pushExpected(input int n, input int k);
        exp_t e;
        for (int w = 0; w < (1 << n); w++) begin
            if ($countones(w) == k) begin
                e.data = 16'(w);
                e.last = 1'b0;
                expQ.push_back(e);
            end
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_back();
            e.last = 1'b1;
            expQ.push_back(e);
        end
    endtask

    // Issue one command to the N=7 instance; returns just after the accepting edge.
    task automatic applyStimulus(input int k);
        @(negedge clk);
        checkOutput("cmd_ready_idle", 32'(bus7.cmd_ready), 32'd1);
        bus7.out_ready = 1'b0;
        bus7.cmd_valid = 1'b1;
        bus7.cmd_count = CW7'(k);
        pushExpected(N7, k);
        @(posedge clk);
    endtask

    // Consume words, checking each visible word (stalled or not) against the queue head.
    task automatic drainOutput(input int readyPct, input int stopAfter,
                               input bit holdCmd, output int words);
        int budget;
        budget = 1000;
        words  = 0;
        while (expQ.size() > 0 && budget > 0 && words != stopAfter) begin
            @(negedge clk);
            budget--;
            bus7.cmd_valid = holdCmd;
            bus7.cmd_count = CW7'(5);
            bus7.out_ready = ($urandom_range(0, 99) < readyPct);
            checkOutput("out_valid_run", 32'(bus7.out_valid), 32'd1);
            checkOutput("out_data", 32'(bus7.out_data), 32'(expQ[0].data));
            checkOutput("out_last", 32'(bus7.out_last), 32'(expQ[0].last));
            if (bus7.out_ready) begin
                void'(expQ.pop_front());
                words++;
            end
        end
        if (budget == 0) begin
            checkOutput("drain_timeout", 32'd0, 32'd1);
        end
    endtask

    // After the last word is taken the generator must be idle again.
    task automatic checkIdle(input string tag);
        @(negedge clk);
        bus7.cmd_valid = 1'b0;
        bus7.out_ready = 1'b0;
        checkOutput({tag, "_valid"}, 32'(bus7.out_valid), 32'd0);
        checkOutput({tag, "_ready"}, 32'(bus7.cmd_ready), 32'd1);
    endtask

    task automatic runSequence(input int k, input int readyPct, input bit holdCmd);
        int words;
        applyStimulus(k);
        drainOutput(readyPct, -1, holdCmd, words);
        checkOutput($sformatf("count_k%0d", k), 32'(words), 32'(binom(N7, k)));
        checkIdle($sformatf("idle_k%0d", k));
    endtask

    initial begin
        int words;
        bus7.cmd_valid = 1'b0;
        bus7.cmd_count = '0;
        bus7.out_ready = 1'b0;
        bus5.cmd_valid = 1'b0;
        bus5.cmd_count = '0;
        bus5.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(bus7.cmd_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus7.out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(bus7.out_data),  32'd0);
        checkOutput("rst_out_last",  32'(bus7.out_last),  32'd0);
        checkOutput("rst_cmd_err",   32'(bus7.cmd_err),   32'd0);
        checkOutput("rst5_cmd_ready", 32'(bus5.cmd_ready), 32'd1);
        rst = 1'b0;

        runSequence(1, 100, 1'b0);
        runSequence(3, 100, 1'b1);
        runSequence(0, 100, 1'b0);
        runSequence(7, 100, 1'b0);
        runSequence(2, 50, 1'b0);
        runSequence(5, 70, 1'b1);

        applyStimulus(4);
        drainOutput(100, 5, 1'b0, words);
        checkOutput("mid_words", 32'(words), 32'd5);
        @(negedge clk);
        rst = 1'b1;
        bus7.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_valid", 32'(bus7.out_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus7.cmd_ready), 32'd1);
        checkOutput("mid_rst_last",  32'(bus7.out_last),  32'd0);
        expQ.delete();
        runSequence(1, 100, 1'b0);

        @(negedge clk);
        checkOutput("n5_ready", 32'(bus5.cmd_ready), 32'd1);
        bus5.cmd_valid = 1'b1;
        bus5.cmd_count = CW5'(6);
        @(negedge clk);
        bus5.cmd_valid = 1'b0;
        checkOutput("n5_err_pulse", 32'(bus5.cmd_err),   32'd1);
        checkOutput("n5_err_valid", 32'(bus5.out_valid), 32'd0);
        checkOutput("n5_err_ready", 32'(bus5.cmd_ready), 32'd1);
        @(negedge clk);
        checkOutput("n5_err_drop",  32'(bus5.cmd_err),   32'd0);
        checkOutput("n5_err_valid2", 32'(bus5.out_valid), 32'd0);
        bus5.cmd_valid = 1'b1;
        bus5.cmd_count = CW5'(5);
        @(negedge clk);
        bus5.cmd_valid = 1'b0;
        checkOutput("n5_full_valid", 32'(bus5.out_valid), 32'd1);
        checkOutput("n5_full_data",  32'(bus5.out_data),  32'h1F);
        checkOutput("n5_full_last",  32'(bus5.out_last),  32'd1);
        checkOutput("n5_full_err",   32'(bus5.cmd_err),   32'd0);
        @(negedge clk);
        checkOutput("n5_done_valid", 32'(bus5.out_valid), 32'd0);
        checkOutput("n5_done_ready", 32'(bus5.cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
